// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch stage that sits directly in front of the ALU. It holds the
// integer register file and reads two source registers for each instruction.
// Operand B is either rs2's register or the immediate. The stage registers
// srcA, srcB, the opcode and the destination into a single-entry valid/ready
// output buffer. ALU results come back through the write-back port.
//
// Optional feature macro: OPERAND_BYPASS_EN
//   defined   : a write-back in the same cycle as a read of the same
//               (non-zero) register forwards wbData into the captured operand.
//   undefined : reads see the pre-write register content. The write becomes
//               visible on the following cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   inValid / inReady     upstream handshake
//   rs1, rs2, imm, aluSrc source selection for operands A and B
//   ALUControlIn, rdIn    opcode and destination, passed through unchanged
//   outValid / outReady   downstream (ALU) handshake
//   srcA, srcB            registered operands
//   ALUControl, rdOut     registered opcode and destination
//   wbEn, wbAddr, wbData  register-file write-back port
// ---------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [AW-1:0]    rs1,
   input  logic [AW-1:0]    rs2,
   input  logic [WIDTH-1:0] imm,
   input  logic             aluSrc,
   input  logic [2:0]       ALUControlIn,
   input  logic [AW-1:0]    rdIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] srcA,
   output logic [WIDTH-1:0] srcB,
   output logic [2:0]       ALUControl,
   output logic [AW-1:0]    rdOut,
   input  logic             wbEn,
   input  logic [AW-1:0]    wbAddr,
   input  logic [WIDTH-1:0] wbData
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] reg_file [NREGS];
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             accept;

   // Register file. Entry 0 is never written, so it stays at its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            reg_file[i] <= '0;
         end
      end else if (wbEn && (wbAddr != '0)) begin
         reg_file[wbAddr] <= wbData;
      end
   end

   // Operand read mux. x0 is forced to zero on the read side as well.
   // The immediate path bypasses the register file entirely.
   always_comb begin
      op_a = '0;
      op_b = '0;
      if (rs1 != '0) begin
         op_a = reg_file[rs1];
`ifdef OPERAND_BYPASS_EN
         if (wbEn && (wbAddr == rs1)) begin
            op_a = wbData;
         end
`endif
      end
      if (aluSrc) begin
         op_b = imm;
      end else if (rs2 != '0) begin
         op_b = reg_file[rs2];
`ifdef OPERAND_BYPASS_EN
         if (wbEn && (wbAddr == rs2)) begin
            op_b = wbData;
         end
`endif
      end
   end

   // inReady depends only on the buffer state and outReady, never on inValid.
   assign inReady = !outValid || outReady;
   assign accept  = inValid && inReady;

   // Output-buffer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. An EMPTY buffer always accepts. A FULL buffer drains
   // only when the ALU takes the entry and nothing new arrives behind it.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (inValid) state_next = FULL;
         FULL:    if (outReady && !inValid) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // Output decode for the handshake.
   always_comb begin
      outValid = (state == FULL);
   end

   // Payload register. It loads only on accept. Operands are a snapshot taken
   // at accept time, so later write-backs never disturb a stalled entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srcA       <= '0;
         srcB       <= '0;
         ALUControl <= 3'b000;
         rdOut      <= '0;
      end else if (accept) begin
         srcA       <= op_a;
         srcB       <= op_b;
         ALUControl <= ALUControlIn;
         rdOut      <= rdIn;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage. It runs in four phases:
//   1. a directed vector table covering write/read, immediate with x0,
//      a stall with snapshot behaviour, and bypass;
//   2. a back-to-back stream of 8 instructions;
//   3. an asynchronous reset applied mid-operation;
//   4. randomized traffic checked against a register-array and
//      expected-transaction-queue reference model.
// Define OPERAND_BYPASS_EN for both the RTL and the bench to test the
// bypass build.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        aluSrc;
   logic [2:0]  ALUControlIn;
   logic [4:0]  rdIn;
   logic        outValid;
   logic        outReady;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [2:0]  ALUControl;
   logic [4:0]  rdOut;
   logic        wbEn;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;

   int testsRun  = 0;
   int testsFail = 0;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        asrc;
      logic [31:0] immv;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        eRdy;
      logic        eValid;
      logic        chkData;
      logic [31:0] eA;
      logic [31:0] eB;
      logic [2:0]  eOp;
      logic [4:0]  eRd;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
   } item_t;

   vec_t vecs[12];

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .inValid(inValid), .inReady(inReady),
      .rs1(rs1), .rs2(rs2), .imm(imm), .aluSrc(aluSrc),
      .ALUControlIn(ALUControlIn), .rdIn(rdIn),
      .outValid(outValid), .outReady(outReady),
      .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .rdOut(rdOut),
      .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(
      input logic iv, input logic ordy, input logic [4:0] r1, input logic [4:0] r2,
      input logic asrc, input logic [31:0] immv, input logic [2:0] op, input logic [4:0] rd,
      input logic we, input logic [4:0] wa, input logic [31:0] wd,
      input logic eRdy, input logic eValid, input logic chkData,
      input logic [31:0] eA, input logic [31:0] eB, input logic [2:0] eOp, input logic [4:0] eRd);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.r1 = r1; v.r2 = r2; v.asrc = asrc; v.immv = immv;
      v.op = op; v.rd = rd; v.we = we; v.wa = wa; v.wd = wd;
      v.eRdy = eRdy; v.eValid = eValid; v.chkData = chkData;
      v.eA = eA; v.eB = eB; v.eOp = eOp; v.eRd = eRd;
      return v;
   endfunction

   // Drive every DUT input from one record.
   task automatic applyStimulus(input vec_t v);
      inValid      = v.iv;
      outReady     = v.ordy;
      rs1          = v.r1;
      rs2          = v.r2;
      aluSrc       = v.asrc;
      imm          = v.immv;
      ALUControlIn = v.op;
      rdIn         = v.rd;
      wbEn         = v.we;
      wbAddr       = v.wa;
      wbData       = v.wd;
   endtask

   // One comparison: count it, and report a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   logic [31:0] bypassA;
   logic [31:0] mregs[32];
   item_t       q[$];

   initial begin
      rst_n = 1'b0;
      idle();

`ifdef OPERAND_BYPASS_EN
      bypassA = 32'h0000_1234;
`else
      bypassA = 32'h0000_0000;
`endif
      //                iv ord r1 r2 as imm           op rd we wa wd           rdy v  chk eA           eB           eOp eRd
      vecs[0]  = mkVec(0, 1, 0, 0, 0, 0,            0, 0, 1, 5, 32'h7,        1, 0, 1, 0,           0,           0, 0);
      vecs[1]  = mkVec(1, 1, 5, 0, 0, 0,            0, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0,           0,           0, 0);
      vecs[2]  = mkVec(1, 1, 0, 0, 1, 32'hFFFFFFFC, 2, 2, 0, 0, 0,            1, 1, 1, 32'h7,       0,           0, 1);
      vecs[3]  = mkVec(1, 1, 5, 0, 0, 0,            3, 3, 0, 0, 0,            1, 1, 1, 0,           32'hFFFFFFFC, 2, 2);
      vecs[4]  = mkVec(1, 0, 6, 5, 0, 0,            4, 4, 0, 0, 0,            0, 1, 1, 32'h7,       0,           3, 3);
      vecs[5]  = mkVec(1, 0, 6, 5, 0, 0,            4, 4, 1, 5, 32'h99,       0, 1, 1, 32'h7,       0,           3, 3);
      vecs[6]  = mkVec(1, 0, 6, 5, 0, 0,            4, 4, 0, 0, 0,            0, 1, 1, 32'h7,       0,           3, 3);
      vecs[7]  = mkVec(1, 1, 6, 5, 0, 0,            4, 4, 0, 0, 0,            1, 1, 1, 32'h7,       0,           3, 3);
      vecs[8]  = mkVec(0, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 1, 1, 0,           32'h99,      4, 4);
      vecs[9]  = mkVec(1, 1, 3, 0, 0, 0,            5, 5, 1, 3, 32'h1234,     1, 0, 0, 0,           0,           0, 0);
      vecs[10] = mkVec(0, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 1, 1, bypassA,     0,           5, 5);
      vecs[11] = mkVec(0, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 0, 0, 0,           0,           0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Phase 1: directed vector table.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d inReady", i), 32'(inReady), 32'(vecs[i].eRdy));
         checkOutput($sformatf("vec%0d outValid", i), 32'(outValid), 32'(vecs[i].eValid));
         if (vecs[i].chkData) begin
            checkOutput($sformatf("vec%0d srcA", i), srcA, vecs[i].eA);
            checkOutput($sformatf("vec%0d srcB", i), srcB, vecs[i].eB);
            checkOutput($sformatf("vec%0d ALUControl", i), 32'(ALUControl), 32'(vecs[i].eOp));
            checkOutput($sformatf("vec%0d rdOut", i), 32'(rdOut), 32'(vecs[i].eRd));
         end
      end

      // Phase 2: 8-instruction back-to-back stream with no bubbles.
      for (int i = 0; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) begin
            applyStimulus(mkVec(1, 1, 0, 0, 1, 32'h100 + 32'(i), 3'(i % 6), 5'(i), 0, 0, 0,
                                0, 0, 0, 0, 0, 0, 0));
         end else begin
            idle();
         end
         @(negedge clk);
         checkOutput($sformatf("stream%0d inReady", i), 32'(inReady), 32'd1);
         if (i > 0) begin
            checkOutput($sformatf("stream%0d outValid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("stream%0d ALUControl", i), 32'(ALUControl), 32'((i - 1) % 6));
            checkOutput($sformatf("stream%0d srcB", i), srcB, 32'h100 + 32'(i - 1));
         end
      end

      // Phase 3: asynchronous reset while an entry is held.
      @(posedge clk); #1;
      applyStimulus(mkVec(1, 0, 5, 5, 0, 0, 3'b111, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      idle();
      outReady = 1'b0;
      @(negedge clk);
      checkOutput("pre-reset outValid", 32'(outValid), 32'd1);
      checkOutput("pre-reset srcA", srcA, 32'h99);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset outValid", 32'(outValid), 32'd0);
      checkOutput("async reset srcA", srcA, 32'd0);
      checkOutput("async reset srcB", srcB, 32'd0);
      checkOutput("async reset ALUControl", 32'(ALUControl), 32'd0);
      checkOutput("async reset rdOut", 32'(rdOut), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(mkVec(1, 1, 5, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("post-reset inReady", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checkOutput("post-reset outValid", 32'(outValid), 32'd1);
      checkOutput("post-reset reg5 srcA", srcA, 32'd0);
      checkOutput("post-reset reg5 srcB", srcB, 32'd0);
      @(posedge clk); #1;
      idle();
      @(negedge clk);

      // Phase 4: randomized traffic against the reference model.
      // The model is a register array plus a queue of expected transactions.
      for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
      q.delete();
      for (int c = 0; c < 400; c++) begin
         logic        acc;
         item_t       it;
         @(posedge clk); #1;
         inValid      = ($urandom_range(0, 3) != 0);
         outReady     = ($urandom_range(0, 3) != 0);
         rs1          = 5'($urandom_range(0, 7));
         rs2          = 5'($urandom_range(0, 7));
         aluSrc       = ($urandom_range(0, 3) == 0);
         imm          = $urandom;
         ALUControlIn = 3'($urandom_range(0, 7));
         rdIn         = 5'($urandom_range(0, 31));
         wbEn         = ($urandom_range(0, 1) == 1);
         wbAddr       = 5'($urandom_range(0, 7));
         wbData       = $urandom;
         @(negedge clk);
         checkOutput("rand inReady", 32'(inReady), 32'((q.size() == 0) || outReady));
         checkOutput("rand outValid", 32'(outValid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            checkOutput("rand srcA", srcA, q[0].a);
            checkOutput("rand srcB", srcB, q[0].b);
            checkOutput("rand ALUControl", 32'(ALUControl), 32'(q[0].op));
            checkOutput("rand rdOut", 32'(rdOut), 32'(q[0].rd));
         end
         acc = inValid && ((q.size() == 0) || outReady);
         if ((q.size() != 0) && outReady) void'(q.pop_front());
         if (acc) begin
            it.a = (rs1 == 0) ? 32'd0 : mregs[rs1];
            it.b = aluSrc ? imm : ((rs2 == 0) ? 32'd0 : mregs[rs2]);
`ifdef OPERAND_BYPASS_EN
            if (wbEn && (wbAddr == rs1) && (rs1 != 0)) it.a = wbData;
            if (!aluSrc && wbEn && (wbAddr == rs2) && (rs2 != 0)) it.b = wbData;
`endif
            it.op = ALUControlIn;
            it.rd = rdIn;
            q.push_back(it);
         end
         if (wbEn && (wbAddr != 0)) mregs[wbAddr] = wbData;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

- Pipeline stage directly upstream of the ALU.
- Holds the 32-entry integer register file, reads two source registers per instruction, and selects register or immediate for operand B.
- Registers `srcA`, `srcB` and `ALUControl` into the ALU stage under a valid/ready handshake.
- Takes the ALU result back through a write-back port, with optional same-cycle write-to-read bypass.

## Interface
- `WIDTH`, 32, datapath width of registers and operands.
- `NREGS`, 32, register count; fixed power of two, address width log2(NREGS)=5.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  upstream instruction present.
- `inReady`  out  1  stage can accept an instruction this cycle.
- `rs1`, `rs2`  in  5  source register addresses.
- `imm`  in  WIDTH  sign-extended immediate.
- `aluSrc`  in  1  0: srcB=reg[rs2]; 1: srcB=imm.
- `ALUControlIn`  in  3  ALU opcode, passed through unmodified.
- `rdIn`  in  5  destination register, passed through.
- `outValid`  out  1  operands valid toward ALU.
- `outReady`  in  1  ALU stage accepts.
- `srcA`, `srcB`  out  WIDTH  registered operands.
- `ALUControl`  out  3  registered opcode.
- `rdOut`  out  5  registered destination.
- `wbEn`  in  1  write-back strobe.
- `wbAddr`  in  5  write-back register.
- `wbData`  in  WIDTH  write-back value (ALU result).

## Operation
- **Register file**
  - Register 0 reads as 0 always; writes to 0 are ignored.
  - Write occurs on the rising edge when `wbEn`=1.
- **Read mux**
  - opA = reg[rs1] (0 if rs1=0).
  - opB = aluSrc ? imm : reg[rs2] (0 if rs2=0 and aluSrc=0).
  - Bypass: see Configuration.
- **Output register**: single entry; states EMPTY (`outValid`=0) and FULL (`outValid`=1).
  - `inReady` = !outValid | outReady (combinational).
  - Accept = inValid & inReady. On accept: capture opA, opB, ALUControlIn, rdIn; outValid<=1.
  - FULL & outReady & !inValid: outValid<=0 (EMPTY).
  - FULL & outReady & inValid: back-to-back load; outValid stays 1.
  - FULL & !outReady: all outputs held stable, bit-exact.
- **Snapshot rule**: captured operands are never updated by later write-backs, even while stalled. RAW hazards older than one cycle are the upstream control's responsibility.
- Simultaneous write-back and read of the same register: governed by `OPERAND_BYPASS_EN`.
- No arithmetic is performed; all widths are passed straight through.

## Timing
- **Reset** (asynchronous assert, synchronous release on first edge after deassert):
  - all registers 0.
  - outValid=0, srcA=0, srcB=0, ALUControl=3'b000, rdOut=0.
  - inReady=1 once reset is released.
- **Reset mid-operation**: a held instruction is discarded and its write-back is lost.
- Latency: 1 cycle from accept to outValid. Throughput: 1 per cycle while outReady=1.
- inReady has a combinational path from outReady only; no path from inValid.
- Write-back is visible to a read in the same cycle with bypass, or the next cycle without it.

## Configuration
- `OPERAND_BYPASS_EN` defined:
  - if wbEn & wbAddr==rs1 & rs1!=0, opA=wbData.
  - same for rs2/opB when aluSrc=0.
- Undefined: reads return the pre-write register content; the write becomes visible the following cycle.

## Test plan
- Reset: hold rst_n=0 mid-run with outValid=1 -> outValid=0, srcA=srcB=0, ALUControl=000 immediately (async); reg[5] reads 0 after release.
- Write then read: wbEn with wbAddr=5, wbData=32'h0000_0007; next cycle rs1=5, rs2=0, aluSrc=0, ALUControlIn=000 -> one cycle later srcA=7, srcB=0, ALUControl=000, outValid=1.
- Immediate and x0: write reg0=32'hFFFF_FFFF, then rs1=0, aluSrc=1, imm=32'hFFFF_FFFC -> srcA=0, srcB=32'hFFFF_FFFC.
- Stall: outReady=0 for 3 cycles with outValid=1 and a new inValid -> inReady=0, outputs unchanged; a write to the captured source register does not alter srcA; outReady=1 -> back-to-back load next cycle.
- Bypass: same cycle wbEn, wbAddr=3, wbData=32'h1234, rs1=3 -> srcA=32'h1234 with `OPERAND_BYPASS_EN`, old value (0) without it.
- Back-to-back stream: 8 instructions, outReady=1, ALUControlIn 000..101 -> 8 consecutive outValid cycles with matching opcode order and no bubbles.
